// File: rtl/aes256_round_sequencer.sv
// Iterative AES-256 encryptor: one shared round datapath stepped over 14 rounds by a small FSM.
// Optional block counter enabled by defining AES_SEQ_PERF_CNT_EN.
package aes256_pkg;
  localparam logic [0:255][7:0] SBOX = {
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
endpackage

module sbox_lane (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  assign dout = aes256_pkg::sbox(din);
endmodule

module sub_bytes (
  input  logic [127:0] din,
  output logic [127:0] dout
);
  for (genvar i = 0; i < 16; i++) begin : g_lane
    sbox_lane u_sbox (.din(din[8*i +: 8]), .dout(dout[8*i +: 8]));
  end
endmodule

// Byte i sits at bits [127-8i -: 8], row i%4, column i/4.
module shiftrows (
  input  logic [127:0] din,
  output logic [127:0] dout
);
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign dout[127-8*(r+4*c) -: 8] = din[127-8*(r+4*((c+r)%4)) -: 8];
    end
  end
endmodule

module mix_column (
  input  logic [31:0] col,
  output logic [31:0] mixed
);
  import aes256_pkg::xtime;
  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = col;
  assign mixed = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                  a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                  a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                  xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
endmodule

module adroundkey (
  input  logic [127:0] din,
  input  logic [127:0] rk,
  output logic [127:0] dout
);
  assign dout = din ^ rk;
endmodule

// The final round shares this datapath; last bypasses MixColumns.
module encryptround (
  input  logic [127:0] din,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] dout
);
  logic [127:0] sb, sr, mc;
  sub_bytes  u_sb (.din(din), .dout(sb));
  shiftrows  u_sr (.din(sb), .dout(sr));
  for (genvar c = 0; c < 4; c++) begin : g_mc
    mix_column u_mc (.col(sr[127-32*c -: 32]), .mixed(mc[127-32*c -: 32]));
  end
  adroundkey u_ark (.din(last ? sr : mc), .rk(rk), .dout(dout));
endmodule

module keyexpansion #(
  parameter int Nr = 14,
  parameter int nk = 8
) (
  input  logic [255:0] key,
  input  logic [3:0]   round,
  output logic [127:0] rk
);
  import aes256_pkg::sub_word;
  localparam int NW = 4*(Nr+1);
  logic [31:0]  w   [NW];
  logic [127:0] rks [Nr+1];

  for (genvar i = 0; i < NW; i++) begin : g_w
    if (i < nk) begin : g_key
      assign w[i] = key[255-32*i -: 32];
    end else if (i % nk == 0) begin : g_rot
      localparam logic [7:0] RCON = 8'(1 << (i/nk - 1));
      assign w[i] = w[i-nk] ^ sub_word({w[i-1][23:0], w[i-1][31:24]}) ^ {RCON, 24'h0};
    end else if (i % nk == 4) begin : g_sub
      assign w[i] = w[i-nk] ^ sub_word(w[i-1]);
    end else begin : g_xor
      assign w[i] = w[i-nk] ^ w[i-1];
    end
  end

  for (genvar r = 0; r <= Nr; r++) begin : g_rk
    assign rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  end

  always_comb begin
    rk = '0;
    for (int r = 0; r <= Nr; r++)
      if (round == 4'(r)) rk = rks[r];
  end
endmodule

module aes256_round_sequencer #(
  parameter int N  = 128,
  parameter int Nr = 14,
  parameter int nk = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [255:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy,
  output logic [31:0]  blk_count
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  state_t       state, state_nxt;
  logic [3:0]   round_cnt, rk_idx;
  logic [N-1:0] state_reg, rnd_out, rk;
  logic [255:0] key_reg;
  logic         accept;

  assign accept = in_valid & in_ready;
  assign rk_idx = (state == FINAL) ? 4'(Nr) : round_cnt;

  keyexpansion #(.Nr(Nr), .nk(nk)) u_kexp (.key(key_reg), .round(rk_idx), .rk(rk));
  encryptround u_rnd (.din(state_reg), .rk(rk), .last(state == FINAL), .dout(rnd_out));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = ROUND;
      ROUND: if (round_cnt == 4'(Nr-1)) state_nxt = FINAL;
      FINAL: state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = accept ? ROUND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready looks at out_ready only, never at in_valid.
  always_comb begin
    in_ready = (state == IDLE) | ((state == DONE) & out_ready);
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= '0;
      key_reg   <= '0;
      round_cnt <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (state == DONE && out_ready) out_valid <= 1'b0;
      if (accept) begin
        // rk[0] is the top half of the raw key, so no expansion is needed to load.
        key_reg   <= in_key;
        state_reg <= in_data ^ in_key[255:128];
        round_cnt <= 4'd1;
      end else if (state == ROUND) begin
        state_reg <= rnd_out;
        if (round_cnt != 4'(Nr-1)) round_cnt <= round_cnt + 4'd1;
      end else if (state == FINAL) begin
        out_data  <= rnd_out;
        out_valid <= 1'b1;
      end
    end
  end

`ifdef AES_SEQ_PERF_CNT_EN
  logic [31:0] blk_cnt_q;
  always_ff @(posedge clk) begin
    if (rst)                         blk_cnt_q <= '0;
    else if (out_valid && out_ready) blk_cnt_q <= blk_cnt_q + 32'd1;
  end
  assign blk_count = blk_cnt_q;
`else
  assign blk_count = 32'd0;
`endif
endmodule

// File: tb/tb_aes256_round_sequencer.sv
// Directed bench for aes256_round_sequencer using the FIPS-197 AES-256 vectors.
module tb_aes256_round_sequencer;
  localparam logic [255:0] K1  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT0 = 128'hdc95c078a2408989ad48a21492842087;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data, out_data;
  logic [255:0] in_key;
  logic [31:0]  blk_count;
  int errors = 0;
  int checks = 0;
  int n;

  aes256_round_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [127:0] pt, input logic [255:0] k);
    in_data  = pt;
    in_key   = k;
    in_valid = 1'b1;
    #1;
    chk("start_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Counts edges from the accept until out_valid; churn scrambles inputs meanwhile.
  task automatic wait_out(input bit churn, output int cnt);
    cnt = 0;
    do begin
      if (churn) begin
        in_data  = {4{$urandom}};
        in_key   = {8{$urandom}};
        in_valid = 1'($urandom_range(0, 1));
      end
      tick();
      cnt++;
    end while (!out_valid && cnt < 40);
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_blk_count", blk_count, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);

    // FIPS-197 C.3 with latency
    start(PT1, K1);
    chk("job_busy", busy, 1);
    chk("job_in_ready", in_ready, 0);
    wait_out(1'b0, n);
    chk("c3_latency", n, 14);
    chk("c3_ct", out_data, CT1);

    // Backpressure
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_data", out_data, CT1);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    tick();
    out_ready = 1'b0;
    chk("bp_drain_valid", out_valid, 0);
    chk("bp_drain_busy", busy, 0);

    // Back-to-back, second job with input churn
    start(PT1, K1);
    wait_out(1'b0, n);
    chk("b2b_first_latency", n, 14);
    chk("b2b_first_ct", out_data, CT1);
    out_ready = 1'b1; in_valid = 1'b1; in_data = '0; in_key = '0;
    #1;
    chk("b2b_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_valid_drop", out_valid, 0);
    chk("b2b_no_idle", busy, 1);
    wait_out(1'b1, n);
    chk("b2b_second_latency", n, 14);
    chk("b2b_second_ct", out_data, CT0);
    chk("churn_in_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("b2b_drain_valid", out_valid, 0);
`ifdef AES_SEQ_PERF_CNT_EN
    chk("blk_count_3", blk_count, 3);
`else
    chk("blk_count_tied", blk_count, 0);
`endif

    // Mid-job reset
    start(PT1, K1);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_blk_count", blk_count, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("mid_rst_quiet", out_valid, 0);
    end
    start(PT1, K1);
    wait_out(1'b0, n);
    chk("after_rst_latency", n, 14);
    chk("after_rst_ct", out_data, CT1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
